// File: rtl/mac_pipe.sv
// mac_pipe: two-stage pipelined unsigned multiply-accumulate with block framing.
// Optional MAC_SATURATE_EN: accumulator saturates instead of wrapping.
module mac_pipe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int LEN    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          x,
    input  logic [DATA_W-1:0]          y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           result,
    output logic                       overflow,
    output logic [$clog2(LEN+1)-1:0]   term_cnt
);

    localparam int CNT_W = $clog2(LEN+1);

    logic [ACC_W-1:0] p1_q, p1_d;
    logic             v1_q, v1_d;
    logic             l1_q, l1_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;

    logic              en;
    logic              accept;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W:0]    sum;
    logic              carry;
    logic [ACC_W-1:0]  acc_next;
    logic [CNT_W:0]    seen;
    logic              last_term;

    // Handshake, product and accumulate arithmetic shared by both stages.
    always_comb begin
        en       = !out_valid_q || out_ready;
        in_ready = !reset && en && !clear;
        accept   = in_valid && in_ready;
        prod     = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
        sum      = {1'b0, acc_q} + {1'b0, p1_q};
        carry    = sum[ACC_W];
`ifdef MAC_SATURATE_EN
        acc_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
        // Terms of the current block already accepted: those accumulated
        // plus one still in stage 1, unless that one closes the prior block.
        if (v1_q && l1_q) begin
            seen = '0;
        end else begin
            seen = {1'b0, term_cnt_q} + {{CNT_W{1'b0}}, v1_q};
        end
        last_term = (seen == (CNT_W+1)'(LEN-1));
    end

    // Stage 1: register the product and mark the last term of a block.
    always_comb begin
        p1_d = p1_q;
        v1_d = v1_q;
        l1_d = l1_q;
        if (clear) begin
            v1_d = 1'b0;
            l1_d = 1'b0;
        end else if (en) begin
            v1_d = accept;
            l1_d = accept && last_term;
            if (accept) begin
                p1_d = ACC_W'(prod);
            end
        end
    end

    // Stage 2 and output register: accumulate, close blocks, hand off.
    always_comb begin
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        term_cnt_d  = term_cnt_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (clear) begin
            acc_d      = '0;
            ovf_acc_d  = 1'b0;
            term_cnt_d = '0;
        end else if (en && v1_q) begin
            if (l1_q) begin
                result_d    = acc_next;
                overflow_d  = ovf_acc_q | carry;
                out_valid_d = 1'b1;
                acc_d       = '0;
                ovf_acc_d   = 1'b0;
                term_cnt_d  = '0;
            end else begin
                acc_d      = acc_next;
                ovf_acc_d  = ovf_acc_q | carry;
                term_cnt_d = term_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_q        <= '0;
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            term_cnt_q  <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            p1_q        <= p1_d;
            v1_q        <= v1_d;
            l1_q        <= l1_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            term_cnt_q  <= term_cnt_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign term_cnt  = term_cnt_q;

endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: directed scoreboard bench for mac_pipe (DATA_W=4, ACC_W=8, LEN=4).
// Honours MAC_SATURATE_EN when expected results are computed.
module tb_mac_pipe;

    localparam int DW = 4;
    localparam int AW = 8;
    localparam int LN = 4;

    logic          clk = 1'b0;
    logic          reset, clear, in_valid, in_ready;
    logic          out_valid, out_ready, overflow;
    logic [DW-1:0] x, y;
    logic [AW-1:0] result;
    logic [2:0]    term_cnt;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    int last_acc = 0;
    int m_sum = 0;
    int m_cnt = 0;
    logic [7:0] pend[$];
    logic [8:0] exp_q[$];
    int         out_cyc[$];

    always #5 clk = ~clk;

    mac_pipe #(.DATA_W(DW), .ACC_W(AW), .LEN(LN)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .term_cnt(term_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive head of pending queue, score output and accept.
    task automatic cyc();
        logic [8:0] e;
        int a, b, r;
        in_valid = (pend.size() > 0);
        if (in_valid) begin
            x = pend[0][7:4];
            y = pend[0][3:0];
        end
        #1;
        if (reset) begin
            m_sum = 0;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_cyc.push_back(ncyc);
                chk("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_result", result, e[7:0]);
                    chk("sb_overflow", overflow, e[8]);
                end
            end
            if (clear) begin
                m_sum = 0;
                m_cnt = 0;
            end
            if (in_valid && in_ready) begin
                a = pend[0][7:4];
                b = pend[0][3:0];
                m_sum += a * b;
                m_cnt++;
                last_acc = ncyc;
                void'(pend.pop_front());
                if (m_cnt == LN) begin
`ifdef MAC_SATURATE_EN
                    r = (m_sum > 255) ? 255 : m_sum;
`else
                    r = m_sum % 256;
`endif
                    exp_q.push_back({(m_sum > 255) ? 1'b1 : 1'b0, r[7:0]});
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
        @(posedge clk);
        ncyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && k < budget) begin
            cyc();
            k++;
        end
        chk(tag, pend.size() + exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; x = '0; y = '0;
        @(negedge clk);
        run(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_term_cnt", term_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Basic block and latency.
        pend = '{8'h12, 8'h13, 8'h25, 8'h33};
        out_cyc.delete();
        drain("basic_drain", 20);
        chk("basic_nout", out_cyc.size(), 1);
        chk("basic_latency", out_cyc[0] - last_acc, 2);
        chk("basic_result", result, 24);
        chk("basic_term_cnt", term_cnt, 0);

        // Overflow.
        pend = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        drain("ovf_drain", 20);
`ifdef MAC_SATURATE_EN
        chk("ovf_result", result, 255);
`else
        chk("ovf_result", result, 132);
`endif
        chk("ovf_flag", overflow, 1);

        // Backpressure: block of 24 then two more blocks (23, 33).
        out_ready = 1'b0;
        pend = '{8'h12, 8'h13, 8'h25, 8'h33,
                 8'h23, 8'h11, 8'h44, 8'h07,
                 8'hF1, 8'h33, 8'h22, 8'h51};
        run(14);
        chk("bp_accepts", pend.size() >= 7, 1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_result_hold", result, 24);
        out_ready = 1'b1;
        out_cyc.delete();
        drain("bp_drain", 60);
        chk("bp_nout", out_cyc.size(), 3);
        chk("bp_last_result", result, 33);

        // Back-to-back blocks.
        repeat (8) pend.push_back(8'h11);
        out_cyc.delete();
        drain("b2b_drain", 40);
        chk("b2b_nout", out_cyc.size(), 2);
        chk("b2b_spacing", out_cyc[1] - out_cyc[0], 4);

        // Clear mid-block; a pair presented with clear is refused.
        pend = '{8'h22, 8'h22};
        drain("clr_pre", 10);
        run(1);
        chk("clr_term_cnt_pre", term_cnt, 2);
        repeat (4) pend.push_back(8'h11);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_term_cnt", term_cnt, 0);
        chk("clr_refused", pend.size(), 4);
        drain("clr_drain", 20);
        chk("clr_result", result, 4);

        // Reset with a partial block.
        pend = '{8'h11, 8'h11};
        drain("rst_mid_pre", 10);
        run(1);
        chk("rst_mid_cnt_pre", term_cnt, 2);
        reset = 1'b1;
        cyc();
        chk("rst_mid_cnt", term_cnt, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        reset = 1'b0;

        // Reset with a pending output.
        out_ready = 1'b0;
        pend = '{8'h12, 8'h12, 8'h12, 8'h12};
        run(8);
        chk("rst_pend_valid_pre", out_valid, 1);
        chk("rst_pend_result_pre", result, 8);
        reset = 1'b1;
        cyc();
        chk("rst_pend_valid", out_valid, 0);
        chk("rst_pend_result", result, 0);
        chk("rst_pend_overflow", overflow, 0);
        chk("rst_pend_cnt", term_cnt, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        pend = '{8'h12, 8'h12, 8'h12, 8'h12};
        out_cyc.delete();
        drain("post_rst_drain", 20);
        chk("post_rst_nout", out_cyc.size(), 1);
        chk("post_rst_result", result, 8);
        chk("post_rst_overflow", overflow, 0);

        run(3);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
